// File: rtl/fnd_src_pkg.sv
// fnd_src_pkg: FSM states, BCD limits and the shift-add-3 digit adjust shared by the FND source mux
package fnd_src_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [23:0] BCD_MAX = 24'h999999;
    localparam logic [19:0] BIN_MAX = 20'd999999;
    localparam int          DIGITS  = 6;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift
    function automatic logic [23:0] bcd_adj(input logic [23:0] a);
        logic [23:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

endpackage

// File: rtl/fnd_src_mux_bin2bcd.sv
// bin2bcd_seq: sequential binary to 6-digit BCD converter, one shift-add-3 step per cycle, saturating at 999999
module bin2bcd_seq
    import fnd_src_pkg::*;
#(
    parameter int BIN_W = 20
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [23:0]      bcd_o
);

    localparam int CW = $clog2(BIN_W + 1);

    logic             run_q;
    logic             sat_q;
    logic [CW-1:0]    cnt_q;
    logic [23:0]      acc_q;
    logic [23:0]      adj;
    logic [BIN_W-1:0] sh_q;

    assign adj    = bcd_adj(acc_q);
    assign done_o = run_q && cnt_q == '0;
    assign bcd_o  = sat_q ? BCD_MAX : acc_q;

    // Load on start, then shift the adjusted accumulator and the binary operand left together once per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            sat_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            sat_q <= 20'(bin_i) > BIN_MAX;
            cnt_q <= CW'(BIN_W);
            acc_q <= '0;
            sh_q  <= bin_i;
        end else if (abort_i || done_o) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            {acc_q, sh_q} <= {adj, sh_q} << 1;
            cnt_q         <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/fnd_src_mux.sv
// fnd_src_mux: registered display-source selector with BCD conversion; FND_AUTO_SCROLL_EN adds tick-driven auto-scroll
module fnd_src_mux
    import fnd_src_pkg::*;
#(
    parameter int             NCH          = 4,
    parameter int             BIN_W        = 20,
    parameter logic [NCH-1:0] BIN_MASK     = 4'b1100,
    parameter int             SCROLL_TICKS = 3,
    localparam int            SW           = $clog2(NCH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_next,
    input  logic              sel_force_en,
    input  logic [SW-1:0]     sel_force,
    input  logic              tick_1s,
    input  logic [NCH*24-1:0] ch_data,
    output logic [SW-1:0]     cur_sel,
    output logic [23:0]       fnd_bcd,
    output logic              fnd_valid,
    output logic              busy
);

    localparam logic [SW-1:0] LAST  = SW'(NCH - 1);
    localparam logic [SW:0]   NCH_L = (SW + 1)'(NCH);

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d, sel_inc, sel_frc;
    logic [23:0]   word, data_q, bcd_q, eng_bcd;
    logic          fmt_q, valid_q, chg, latch, wr, eng_done, auto_adv;

    assign word    = ch_data[sel_q*24 +: 24];
    assign sel_inc = (sel_q == LAST) ? '0 : sel_q + 1'b1;
    assign sel_frc = ({1'b0, sel_force} >= NCH_L) ? LAST : sel_force;

`ifdef FND_AUTO_SCROLL_EN
    localparam int TW = $clog2(SCROLL_TICKS + 1);

    logic [TW-1:0] dwell_q;

    assign auto_adv = tick_1s && !sel_force_en && dwell_q == TW'(SCROLL_TICKS - 1);

    // Dwell counter: counts ticks on the current channel; any manual change or an auto advance restarts it
    always_ff @(posedge clk) begin
        if (!rst_n) dwell_q <= '0;
        else if (sel_next || sel_force_en || auto_adv) dwell_q <= '0;
        else if (tick_1s) dwell_q <= dwell_q + 1'b1;
    end
`else
    logic unused_tick;

    assign unused_tick = tick_1s;
    assign auto_adv    = 1'b0;
`endif

    // Channel selection by priority and the IDLE/CONV/DONE sequencing; a channel change restarts from IDLE
    always_comb begin
        sel_d   = sel_force_en ? sel_frc : (sel_next || auto_adv) ? sel_inc : sel_q;
        chg     = sel_d != sel_q;
        latch   = state_q == IDLE && !chg;
        wr      = state_q == CONV && !chg && (!fmt_q || eng_done);
        state_d = (state_q == IDLE) ? (chg ? IDLE : CONV) :
                  (state_q == CONV) ? (chg ? IDLE : (wr ? DONE : CONV)) : IDLE;
    end

    bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(latch && BIN_MASK[sel_q]),
        .abort_i(state_q == CONV && chg),
        .bin_i  (word[BIN_W-1:0]),
        .done_o (eng_done),
        .bcd_o  (eng_bcd)
    );

    // State, sample latch and output register; fnd_bcd only moves together with the fnd_valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            state_q <= IDLE;
            data_q  <= '0;
            fmt_q   <= 1'b0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            state_q <= state_d;
            valid_q <= wr;
            if (latch) begin
                data_q <= word;
                fmt_q  <= BIN_MASK[sel_q];
            end
            if (wr) bcd_q <= fmt_q ? eng_bcd : data_q;
        end
    end

    assign cur_sel   = sel_q;
    assign fnd_bcd   = bcd_q;
    assign fnd_valid = valid_q;
    assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_fnd_src_mux.sv
// tb_fnd_src_mux: directed self-checking bench for fnd_src_mux (default parameters; auto-scroll tests follow FND_AUTO_SCROLL_EN)
module tb_fnd_src_mux;

    logic        clk = 1'b0;
    logic        rst_n, sel_next, sel_force_en, tick_1s;
    logic [1:0]  sel_force, cur_sel;
    logic [95:0] ch_data;
    logic [23:0] fnd_bcd;
    logic        fnd_valid, busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fnd_src_mux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_next    (sel_next),
        .sel_force_en(sel_force_en),
        .sel_force   (sel_force),
        .tick_1s     (tick_1s),
        .ch_data     (ch_data),
        .cur_sel     (cur_sel),
        .fnd_bcd     (fnd_bcd),
        .fnd_valid   (fnd_valid),
        .busy        (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            cyc();
            ok = fnd_valid;
        end
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_next = 1'b0; sel_force_en = 1'b0; sel_force = 2'd0; tick_1s = 1'b0;
        ch_data[0*24 +: 24] = 24'h123456;
        ch_data[1*24 +: 24] = 24'h654321;
        ch_data[2*24 +: 24] = 24'd347;
        ch_data[3*24 +: 24] = 24'h0FFFFF;
        repeat (3) cyc();
        checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel got %0d want 0", cur_sel); end
        checks++; if (fnd_bcd !== 24'h000000) begin errors++; $display("FAIL reset_fnd_bcd got %h want 000000", fnd_bcd); end
        checks++; if (fnd_valid !== 1'b0) begin errors++; $display("FAIL reset_fnd_valid got %b want 0", fnd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_conv_busy got %b want 1", busy); end
        checks++; if (fnd_valid !== 1'b0) begin errors++; $display("FAIL first_conv_valid got %b want 0", fnd_valid); end
        cyc();
        checks++; if (fnd_valid !== 1'b1) begin errors++; $display("FAIL first_done_valid got %b want 1", fnd_valid); end
        checks++; if (fnd_bcd !== 24'h123456) begin errors++; $display("FAIL first_done_bcd got %h want 123456", fnd_bcd); end
        checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL first_done_sel got %0d want 0", cur_sel); end
        cyc();
        checks++; if (fnd_valid !== 1'b0) begin errors++; $display("FAIL first_idle_valid got %b want 0", fnd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_bcd_stream();
        int  n = 0;
        bit  prev = 1'b0;
        bit  back = 1'b0;
        ch_data[0*24 +: 24] = 24'h0A0F00;
        for (int k = 0; k < 9; k++) begin
            cyc();
            if (fnd_valid) n++;
            if (fnd_valid && prev) back = 1'b1;
            prev = fnd_valid;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL bcd_period_pulses got %0d want 3", n); end
        checks++; if (back !== 1'b0) begin errors++; $display("FAIL bcd_back_to_back got %b want 0", back); end
        checks++; if (fnd_bcd !== 24'h0A0F00) begin errors++; $display("FAIL bcd_passthrough got %h want 0a0f00", fnd_bcd); end
    endtask

    task automatic test_forced_binary(input logic [1:0] ch, input logic [23:0] prev, input logic [23:0] exp);
        bit ok = 1'b1;
        if (!fnd_valid) wait_valid(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL force%0d_sync_timeout got none want fnd_valid", ch); end
        sel_force_en = 1'b1;
        sel_force    = ch;
        for (int k = 1; k <= 23; k++) begin
            cyc();
            checks++; if (fnd_valid !== (k == 23)) begin errors++; $display("FAIL force%0d_valid k=%0d got %b want %b", ch, k, fnd_valid, k == 23); end
            checks++; if (busy !== (k >= 2)) begin errors++; $display("FAIL force%0d_busy k=%0d got %b want %b", ch, k, busy, k >= 2); end
            checks++; if (fnd_bcd !== ((k == 23) ? exp : prev)) begin errors++; $display("FAIL force%0d_bcd k=%0d got %h want %h", ch, k, fnd_bcd, (k == 23) ? exp : prev); end
        end
        checks++; if (cur_sel !== ch) begin errors++; $display("FAIL force%0d_sel got %0d want %0d", ch, cur_sel, ch); end
    endtask

    task automatic test_abort();
        ch_data[3*24 +: 24] = 24'h00FFFF;
        sel_force = 2'd2;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++; if (fnd_valid !== 1'b0) begin errors++; $display("FAIL abort_pre_valid k=%0d got %b want 0", k, fnd_valid); end
        end
        checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL abort_pre_sel got %0d want 2", cur_sel); end
        sel_force_en = 1'b0;
        sel_next     = 1'b1;
        cyc();
        sel_next = 1'b0;
        checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL abort_sel got %0d want 3", cur_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (fnd_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", fnd_valid); end
        for (int j = 1; j <= 22; j++) begin
            cyc();
            checks++; if (fnd_valid !== (j == 22)) begin errors++; $display("FAIL abort_valid j=%0d got %b want %b", j, fnd_valid, j == 22); end
            checks++; if (fnd_bcd !== ((j == 22) ? 24'h065535 : 24'h999999)) begin errors++; $display("FAIL abort_bcd j=%0d got %h want %h", j, fnd_bcd, (j == 22) ? 24'h065535 : 24'h999999); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        sel_next = 1'b1;
        cyc();
        sel_next = 1'b0;
        checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel got %0d want 0", cur_sel); end
        sel_next = 1'b1;
        cyc();
        sel_next = 1'b0;
        checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL next_sel got %0d want 1", cur_sel); end
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL next_timeout got none want fnd_valid"); end
        checks++; if (fnd_bcd !== 24'h654321) begin errors++; $display("FAIL next_bcd got %h want 654321", fnd_bcd); end
    endtask

`ifdef FND_AUTO_SCROLL_EN
    task automatic test_scroll();
        repeat (2) pulse_tick();
        checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL scroll_two_ticks got %0d want 1", cur_sel); end
        pulse_tick();
        checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL scroll_three_ticks got %0d want 2", cur_sel); end
        repeat (2) pulse_tick();
        tick_1s  = 1'b1;
        sel_next = 1'b1;
        cyc();
        tick_1s  = 1'b0;
        sel_next = 1'b0;
        checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL scroll_coincident got %0d want 3", cur_sel); end
        repeat (2) pulse_tick();
        checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL scroll_cleared got %0d want 3", cur_sel); end
        pulse_tick();
        checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL scroll_wrap got %0d want 0", cur_sel); end
        sel_force_en = 1'b1;
        sel_force    = 2'd1;
        repeat (4) pulse_tick();
        checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL scroll_forced got %0d want 1", cur_sel); end
        sel_force_en = 1'b0;
    endtask
`else
    task automatic test_scroll();
        repeat (4) pulse_tick();
        checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL tick_ignored got %0d want 1", cur_sel); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bcd_stream();
        test_forced_binary(2'd2, 24'h0A0F00, 24'h000347);
        test_forced_binary(2'd3, 24'h000347, 24'h999999);
        test_abort();
        test_wrap();
        test_scroll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
